// File: rtl/bcd_conv_pkg.sv
// Shared types and default widths for the binary-to-BCD converter arbiter.
package bcd_conv_pkg;

  localparam int BIN_W = 27;
  localparam int BCD_W = 36;
  localparam int TMO   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic [PW:0]   raw_s;
  logic [PW:0]   sum_s;
  logic [PW-1:0] cand_s;
  logic          hit_s;

  // Walk the requesters starting at ptr, wrapping at NREQ, and keep the first hit.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    raw_s  = '0;
    sum_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      raw_s         = {1'b0, ptr} + (PW+1)'(i);
      sum_s         = (raw_s >= (PW+1)'(NREQ)) ? (raw_s - (PW+1)'(NREQ)) : raw_s;
      cand_s        = sum_s[PW-1:0];
      hit_s         = ~any & req[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      idx           = hit_s ? cand_s : idx;
      any           = any | hit_s;
    end
  end

endmodule

// File: rtl/bcd_conv_arb.sv
// Round-robin scheduler sharing one multi-cycle binary-to-BCD converter between
// several display requesters, with result routing and a converter stall timeout.
module bcd_conv_arb #(
  parameter int NREQ  = 3,
  parameter int BIN_W = bcd_conv_pkg::BIN_W,
  parameter int BCD_W = bcd_conv_pkg::BCD_W,
  parameter int TMO   = bcd_conv_pkg::TMO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*BIN_W-1:0] req_bin,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic                  rsp_err,
  output logic [BCD_W-1:0]      rsp_bcd,
  output logic                  cv_bin_valid,
  output logic [BIN_W-1:0]      cv_bin,
  input  logic                  cv_ready,
  input  logic                  cv_bcd_valid,
  input  logic [BCD_W-1:0]      cv_bcd,
  output logic                  busy
);

  import bcd_conv_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     own_q, own_d;
  logic [BIN_W-1:0]  op_q, op_d;
  logic              cv_bin_valid_q, cv_bin_valid_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [BCD_W-1:0]  rsp_bcd_q, rsp_bcd_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   pick_grant_s;
  logic [PW-1:0]     pick_idx_s;
  logic              pick_any_s;
  logic [BIN_W-1:0]  pick_bin_s;
  logic [NREQ-1:0]   own_onehot_s;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Operand of the current winner, and one-hot decode of the owner in flight.
  always_comb begin
    pick_bin_s   = '0;
    own_onehot_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_bin_s      = pick_bin_s | ({BIN_W{pick_grant_s[i]}} & req_bin[i*BIN_W +: BIN_W]);
      own_onehot_s[i] = (own_q == PW'(i));
    end
  end

  // Grants are only offered while idle, so at most one conversion is in flight.
  always_comb begin
    if (state_q == ST_IDLE) begin
      req_ready = pick_grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and next-output computation for the scheduler.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    own_d          = own_q;
    op_d           = op_q;
    cv_bin_valid_d = cv_bin_valid_q;
    cnt_d          = cnt_q;
    rsp_valid_d    = '0;
    rsp_err_d      = rsp_err_q;
    rsp_bcd_d      = rsp_bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          op_d           = pick_bin_s;
          own_d          = pick_idx_s;
          ptr_d          = (pick_idx_s == PW'(NREQ-1)) ? '0 : (pick_idx_s + PW'(1));
          cv_bin_valid_d = 1'b1;
          state_d        = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cv_ready) begin
          cv_bin_valid_d = 1'b0;
          cnt_d          = '0;
          state_d        = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A result arriving on the timeout cycle takes precedence over the abort.
        if (cv_bcd_valid) begin
          rsp_bcd_d   = cv_bcd;
          rsp_err_d   = 1'b0;
          rsp_valid_d = own_onehot_s;
          state_d     = ST_RESP;
        end else if (cnt_q == CW'(TMO-1)) begin
          rsp_err_d   = 1'b1;
          rsp_valid_d = own_onehot_s;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        rsp_err_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        cv_bin_valid_d = 1'b0;
        rsp_err_d      = 1'b0;
        state_d        = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      own_q          <= '0;
      op_q           <= '0;
      cv_bin_valid_q <= 1'b0;
      cnt_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_bcd_q      <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      own_q          <= own_d;
      op_q           <= op_d;
      cv_bin_valid_q <= cv_bin_valid_d;
      cnt_q          <= cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_bcd_q      <= rsp_bcd_d;
      busy_q         <= busy_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_bcd      = rsp_bcd_q;
  assign cv_bin_valid = cv_bin_valid_q;
  assign cv_bin       = op_q;
  assign busy         = busy_q;

endmodule

// File: doc/bcd_conv_arb.md
# bcd_conv_arb

Round-robin scheduler that shares the single multi-cycle binary-to-BCD converter among `NREQ` requesters: operand A display, operand B display, and product display. It sits between the operand/result registers of the multiplier top level and the `bin_bcd` instance. It serialises conversions, routes each BCD result back to the requester that issued it, and recovers from a stalled converter with a timeout.

## Interface
Parameters:
- `NREQ`, 3, number of requesters (2..8)
- `BIN_W`, 27, binary operand width
- `BCD_W`, 36, BCD result width
- `TMO`, 64, maximum cycles in WAIT before abort (≥4)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester conversion request
- `req_bin`  in  NREQ*BIN_W  packed operands; requester i at `[i*BIN_W +: BIN_W]`
- `req_ready`  out  NREQ  one-hot accept; handshake when `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  NREQ  one-hot, one-cycle result strobe
- `rsp_err`  out  1  high with `rsp_valid` when the conversion timed out
- `rsp_bcd`  out  BCD_W  result; holds its value until the next response
- `cv_bin_valid`  out  1  to converter `bin_valid`
- `cv_bin`  out  BIN_W  to converter `bin`
- `cv_ready`  in  1  converter idle/accepting
- `cv_bcd_valid`  in  1  converter result strobe
- `cv_bcd`  in  BCD_W  converter result
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready` is the combinational one-hot winner of `req_valid` under round-robin priority. The search starts at index `ptr`; `ptr` resets to 0.
  - On a handshake: latch the operand into `op_q`, latch the owner index into `own_q`, set `ptr` to `own_q+1` (wrapping at `NREQ`), then go to ISSUE.
  - No valid requests: `req_ready = 0`.
- **ISSUE**
  - `cv_bin_valid = 1` and `cv_bin = op_q`, both held stable until `cv_ready = 1`. On that cycle go to WAIT and clear the timeout counter.
  - ISSUE has no timeout.
- **WAIT**
  - `cv_bin_valid = 0`. The counter increments every cycle.
  - `cv_bcd_valid`: capture `cv_bcd` into `rsp_bcd`, clear the error flag, go to RESP.
  - Counter reaches `TMO-1` with no result: set the error flag, leave `rsp_bcd` unchanged, go to RESP.
  - If `cv_bcd_valid` and timeout occur in the same cycle, the result wins and no error is flagged.
- **RESP**
  - `rsp_valid[own_q] = 1` for exactly one cycle; `rsp_err` equals the error flag.
  - Next cycle is IDLE.
- `cv_bcd_valid` outside WAIT is ignored, and `rsp_bcd` does not change.
- Requesters may drop `req_valid` before a handshake; no state is affected. A requester's operand is sampled only on its handshake cycle.
- `req_ready` is 0 in every state except IDLE. One conversion is in flight at most.
- **Reset values:** state IDLE, `ptr = 0`, `req_ready = 0`, `rsp_valid = 0`, `rsp_err = 0`, `rsp_bcd = 0`, `cv_bin_valid = 0`, `cv_bin = 0`, `busy = 0`.
- **Reset mid-operation:** immediate return to reset values. An in-flight converter result arriving after reset is ignored, because the block is not in WAIT.

## Timing
- Handshake at cycle N (IDLE). ISSUE at N+1, with `cv_bin_valid` high from N+1.
- Converter accepts at cycle A ≥ N+1. WAIT from A+1.
- `cv_bcd_valid` at cycle M ≥ A+1. RESP at M+1 (`rsp_valid` and `rsp_bcd` visible). IDLE at M+2, so the next handshake is possible at M+2.
- Minimum request-to-response latency: 3 cycles plus converter latency.
- Timeout: WAIT entered at A+1; `rsp_valid` with `rsp_err = 1` at A+1+TMO.
- All outputs are registered except `req_ready`, which is combinational from `req_valid`, `ptr` and state.

## Structure
- Shared package `bcd_conv_pkg`:
  - state enum (`ST_IDLE`, `ST_ISSUE`, `ST_WAIT`, `ST_RESP`)
  - default width constants `BIN_W` and `BCD_W`
  - the `TMO` default
- One sub-module, `rr_pick`: parameterised `NREQ` combinational round-robin picker. Inputs are the request vector and `ptr`; outputs are the one-hot grant, the encoded index, and `any`.
- The counter width is `$clog2(TMO)`; `own_q` and `ptr` are `$clog2(NREQ)` wide (minimum 1).

## Test plan
- **Single request:** `req_bin[0] = 12345`, converter model with `cv_ready = 1` and a 10-cycle latency returning BCD `0x12345`. Expect `req_ready[0]` at N, `cv_bin_valid` at N+1, `rsp_valid = 3'b001` at N+12, `rsp_bcd = 0x12345`, `rsp_err = 0`.
- **Round robin:** all three requests held valid continuously, each with a distinct operand. Expect grants in order 0,1,2,0; each `rsp_valid` index matches its operand's BCD.
- **Backpressure:** `cv_ready = 0` for 20 cycles after issue. Expect `cv_bin_valid` high and `cv_bin` stable throughout, with no timeout; the response follows normally.
- **Timeout:** the converter never asserts `cv_bcd_valid`, with `TMO = 64`. Expect `rsp_valid[own]` with `rsp_err = 1` exactly 64 cycles after WAIT entry, `rsp_bcd` unchanged, then IDLE. Also, `cv_bcd_valid` on the exact timeout cycle gives `rsp_err = 0`.
- **Reset mid-WAIT:** assert `rst = 0` asynchronously during WAIT. Expect all outputs at reset values immediately. A late `cv_bcd_valid` produces no `rsp_valid`, and the first grant after reset goes to requester 0.
- **Spurious result:** pulse `cv_bcd_valid` while in IDLE. Expect no `rsp_valid` and `rsp_bcd` unchanged.
